// File: rtl/jk_bank_sched.sv
// jk_bank_sched
//   Round-robin scheduler that lets NREQ requesters share one WIDTH-bit JK
//   flip-flop bank. Each winning command is latched in IDLE, drives the
//   bank's J/K lines for one cycle in APPLY, and is acknowledged in RESP.
//   This gives one command every 3 cycles.
//
//   Build option: define JK_BANK_SCHED_FIXED_PRIO_EN to make the lowest
//   requester index always win. The round-robin pointer is then not built.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]        request pending per requester
//   req_op     in   [2*NREQ]      op of requester i at [2i+1:2i]
//                                 00 hold, 01 clear, 10 set, 11 toggle
//   req_mask   in   [WIDTH*NREQ]  bit mask of requester i
//   req_ack    out  [NREQ]        one-cycle one-hot completion pulse
//   jk_j/jk_k  out  [WIDTH]       J/K drive, nonzero only in APPLY
//   q          out  [WIDTH]       bank contents
//   busy       out  1             high whenever the FSM is not idle
module jk_bank_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [2*NREQ-1:0]      req_op,
    input  logic [WIDTH*NREQ-1:0]  req_mask,
    output logic [NREQ-1:0]        req_ack,
    output logic [WIDTH-1:0]       jk_j,
    output logic [WIDTH-1:0]       jk_k,
    output logic [WIDTH-1:0]       q,
    output logic                   busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     win_q, win_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [WIDTH-1:0]  q_q, q_d;

    logic              grant_found;
    logic [IW-1:0]     grant_idx;
    logic [IW-1:0]     cand_idx;
    int                cand;
    logic [1:0]        op_sel;
    logic [WIDTH-1:0]  mask_sel;

`ifndef JK_BANK_SCHED_FIXED_PRIO_EN
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
`endif

    // The scan starts at rr_ptr in round-robin mode and at 0 in fixed-priority mode.
    // The first valid requester found in the scan wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef JK_BANK_SCHED_FIXED_PRIO_EN
            cand = i;
`else
            cand = (int'(rr_ptr_q) + i) % NREQ;
`endif
            cand_idx = IW'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        op_sel   = '0;
        mask_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
                op_sel   = req_op[2*i +: 2];
                mask_sel = req_mask[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        op_d     = op_q;
        mask_d   = mask_q;
        q_d      = q_q;
        jk_j     = '0;
        jk_k     = '0;
`ifndef JK_BANK_SCHED_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    win_d   = grant_idx;
                    op_d    = op_sel;
                    mask_d  = mask_sel;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                jk_j    = op_q[1] ? mask_q : '0;
                jk_k    = op_q[0] ? mask_q : '0;
                // Characteristic JK equation: q+ = J & ~q | ~K & q
                q_d     = (jk_j & ~q_q) | (~jk_k & q_q);
                state_d = S_RESP;
            end
            S_RESP: begin
`ifndef JK_BANK_SCHED_FIXED_PRIO_EN
                if (win_q == IW'(NREQ - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = win_q + 1'b1;
                end
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            win_q    <= '0;
            op_q     <= '0;
            mask_q   <= '0;
            q_q      <= '0;
`ifndef JK_BANK_SCHED_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            op_q     <= op_d;
            mask_q   <= mask_d;
            q_q      <= q_d;
`ifndef JK_BANK_SCHED_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    always_comb begin
        req_ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ack[i] = (state_q == S_RESP) && (win_q == IW'(i));
        end
    end

    assign q    = q_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_jk_bank_sched.sv
module tb_jk_bank_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_mask;
    logic [NREQ-1:0]       req_ack;
    logic [WIDTH-1:0]      jk_j;
    logic [WIDTH-1:0]      jk_k;
    logic [WIDTH-1:0]      q;
    logic                  busy;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] qv;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               ack_count = 0;
    logic [WIDTH-1:0] model_q = '0;

    jk_bank_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_mask  (req_mask),
        .req_ack   (req_ack),
        .jk_j      (jk_j),
        .jk_k      (jk_k),
        .q         (q),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] jk_model(input logic [WIDTH-1:0] cur,
                                                  input logic [1:0] op,
                                                  input logic [WIDTH-1:0] m);
        logic [WIDTH-1:0] r;
        r = cur;
        for (int b = 0; b < WIDTH; b++) begin
            if (m[b]) begin
                case (op)
                    2'b01:   r[b] = 1'b0;
                    2'b10:   r[b] = 1'b1;
                    2'b11:   r[b] = ~cur[b];
                    default: r[b] = cur[b];
                endcase
            end
        end
        return r;
    endfunction

    // Scoreboard consumer: every ack must match the oldest expected command.
    always @(negedge clk) begin
        if (rst_n && req_ack !== '0) begin
            ack_count++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack ack=%b with empty scoreboard", req_ack);
            end else begin
                exp_t e;
                logic [NREQ-1:0] want;
                e = sb.pop_front();
                want = '0;
                want[e.idx] = 1'b1;
                if (req_ack !== want || q !== e.qv) begin
                    errors++;
                    $display("FAIL sb_ack got ack=%b q=%h expected ack=%b q=%h",
                             req_ack, q, want, e.qv);
                end
            end
        end
    end

    task automatic drive_req(input int i, input logic [1:0] op,
                             input logic [WIDTH-1:0] m, input logic v);
        req_op[2*i +: 2]           = op;
        req_mask[WIDTH*i +: WIDTH] = m;
        req_valid[i]               = v;
    endtask

    // Issue one command from a negedge, wait for its ack, drop valid and
    // return one negedge later with the FSM back in IDLE. lat = -1 on timeout.
    task automatic issue(input int i, input logic [1:0] op,
                         input logic [WIDTH-1:0] m, output int lat);
        exp_t e;
        model_q = jk_model(model_q, op, m);
        e.idx = i;
        e.qv  = model_q;
        sb.push_back(e);
        drive_req(i, op, m, 1'b1);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (req_ack[i] === 1'b1) begin
                lat = c;
                break;
            end
        end
        req_valid[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        checks++;
        if (q !== 8'h00 || req_ack !== 4'b0000 || busy !== 1'b0 ||
            jk_j !== 8'h00 || jk_k !== 8'h00) begin
            errors++;
            $display("FAIL reset_state q=%h ack=%b busy=%b j=%h k=%h expected all zero",
                     q, req_ack, busy, jk_j, jk_k);
        end
    endtask

    task automatic test_set_single;
        int lat;
        drive_req(0, 2'b10, 8'h0F, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || jk_j !== 8'h0F || jk_k !== 8'h00 || req_ack !== 4'b0000 || q !== 8'h00) begin
            errors++;
            $display("FAIL set_apply busy=%b j=%h k=%h ack=%b q=%h expected 1 0f 00 0000 00",
                     busy, jk_j, jk_k, req_ack, q);
        end
        req_valid[0] = 1'b0;
        // Scoreboard entry for the command already in flight.
        model_q = jk_model(model_q, 2'b10, 8'h0F);
        sb.push_back('{idx: 0, qv: model_q});
        drive_req(0, 2'b10, 8'h0F, 1'b1);
        @(negedge clk);
        checks++;
        if (req_ack !== 4'b0001 || q !== 8'h0F || jk_j !== 8'h00) begin
            errors++;
            $display("FAIL set_resp ack=%b q=%h j=%h expected 0001 0f 00", req_ack, q, jk_j);
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ack !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL set_idle ack=%b busy=%b expected 0000 0", req_ack, busy);
        end
        issue(0, 2'b00, 8'hFF, lat);
        checks++;
        if (lat !== 2 || q !== 8'h0F) begin
            errors++;
            $display("FAIL hold_op lat=%0d q=%h expected 2 0f", lat, q);
        end
    endtask

    task automatic test_toggle;
        int lat;
        issue(2, 2'b11, 8'hFF, lat);
        checks++;
        if (lat !== 2 || q !== 8'hF0) begin
            errors++;
            $display("FAIL toggle1 lat=%0d q=%h expected 2 f0", lat, q);
        end
        issue(2, 2'b11, 8'hFF, lat);
        checks++;
        if (lat !== 2 || q !== 8'h0F) begin
            errors++;
            $display("FAIL toggle2 lat=%0d q=%h expected 2 0f", lat, q);
        end
    endtask

    task automatic test_zero_mask;
        int lat;
        int jk_bad;
        int acks_seen;
        issue(0, 2'b10, 8'hFF, lat);
        checks++;
        if (lat !== 2 || q !== 8'hFF) begin
            errors++;
            $display("FAIL zero_mask_setup lat=%0d q=%h expected 2 ff", lat, q);
        end
        model_q = jk_model(model_q, 2'b01, 8'h00);
        sb.push_back('{idx: 1, qv: model_q});
        drive_req(1, 2'b01, 8'h00, 1'b1);
        jk_bad = 0;
        acks_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (jk_j !== 8'h00 || jk_k !== 8'h00) jk_bad++;
            if (req_ack[1] === 1'b1) begin
                acks_seen++;
                req_valid[1] = 1'b0;
            end
        end
        checks++;
        if (jk_bad !== 0 || acks_seen !== 1 || q !== 8'hFF) begin
            errors++;
            $display("FAIL zero_mask jk_nonzero_cycles=%0d acks=%0d q=%h expected 0 1 ff",
                     jk_bad, acks_seen, q);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int acks_before;
        issue(3, 2'b01, 8'hFF, lat);
        issue(1, 2'b10, 8'hA5, lat);
        checks++;
        if (q !== 8'hA5) begin
            errors++;
            $display("FAIL reset_mid_setup q=%h expected a5", q);
        end
        drive_req(0, 2'b11, 8'hFF, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || jk_j !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid_apply busy=%b j=%h expected 1 ff", busy, jk_j);
        end
        acks_before = ack_count;
        rst_n = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || req_ack !== 4'b0000 || jk_j !== 8'h00 || jk_k !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_clear q=%h busy=%b ack=%b j=%h k=%h expected all zero",
                     q, busy, req_ack, jk_j, jk_k);
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_q = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (ack_count !== acks_before || req_ack !== 4'b0000 || q !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_noack acks=%0d ack=%b q=%h expected %0d 0000 00",
                     ack_count, req_ack, q, acks_before);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0]       ops[NREQ];
        logic [WIDTH-1:0] masks[NREQ];
        int               order[5];
        int               ack_cyc[5];
        int               n;
        int               cyc;
        ops[0] = 2'b11; masks[0] = 8'h01;
        ops[1] = 2'b10; masks[1] = 8'h10;
        ops[2] = 2'b11; masks[2] = 8'hFF;
        ops[3] = 2'b01; masks[3] = 8'h0F;
        for (int k = 0; k < 5; k++) begin
`ifdef JK_BANK_SCHED_FIXED_PRIO_EN
            order[k] = 0;
`else
            order[k] = k % NREQ;
`endif
            model_q = jk_model(model_q, ops[order[k]], masks[order[k]]);
            sb.push_back('{idx: order[k], qv: model_q});
        end
        for (int i = 0; i < NREQ; i++) drive_req(i, ops[i], masks[i], 1'b1);
        n = 0;
        cyc = 0;
        while (n < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (req_ack !== '0) begin
                ack_cyc[n] = cyc;
                n++;
                if (n == 5) req_valid = '0;
            end
        end
        req_valid = '0;
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL b2b_count acks=%0d expected 5", n);
        end else begin
            checks++;
            if (ack_cyc[0] !== 2) begin
                errors++;
                $display("FAIL b2b_first_latency got %0d expected 2", ack_cyc[0]);
            end
            for (int k = 1; k < 5; k++) begin
                checks++;
                if (ack_cyc[k] - ack_cyc[k-1] !== 3) begin
                    errors++;
                    $display("FAIL b2b_spacing k=%0d got %0d expected 3", k, ack_cyc[k] - ack_cyc[k-1]);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain pending=%0d busy=%b expected 0 0", sb.size(), busy);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_mask  = '0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_set_single;
        test_toggle;
        test_zero_mask;
        test_reset_mid;
        test_back_to_back;
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_leftover pending=%0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_bank_sched.md
# jk_bank_sched

Round-robin command scheduler that shares one WIDTH-bit JK flip-flop register bank between NREQ requesters. Each requester posts a JK command (hold/clear/set/toggle) with a per-bit mask; the block arbitrates, drives the bank's J/K lines for exactly one cycle and acknowledges the winner. It owns the bank state, sits between the control requesters and the JK storage, and presents the bank contents as `q`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: bank width in bits.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  request pending, bit i = requester i.
- `req_op`  in  2*NREQ  op of requester i at [2i+1:2i]: 00 hold, 01 clear, 10 set, 11 toggle.
- `req_mask`  in  WIDTH*NREQ  bit mask of requester i at [WIDTH*(i+1)-1:WIDTH*i].
- `req_ack`  out  NREQ  one-cycle completion pulse, one-hot.
- `jk_j`, `jk_k`  out  WIDTH each  J/K drive to bank, nonzero only in APPLY.
- `q`  out  WIDTH  bank contents.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, APPLY, RESP.
- IDLE: if any `req_valid`, select winner (round-robin starting at `rr_ptr`), latch its op, mask and index, go APPLY; otherwise stay.
- APPLY: per bit b, if mask[b]=0 then J=K=0; else J/K = op (00→0/0, 01→0/1, 10→1/0, 11→1/1). At the clock edge `q[b]` updates per JK rule: 00 hold, 01 → 0, 10 → 1, 11 → ~q[b]. Go RESP.
- RESP: `req_ack[winner]`=1; at the edge `rr_ptr` ← (winner+1) mod NREQ, go IDLE.
- Latched command is immune to input changes after IDLE; requester dropping `req_valid` before ack does not cancel it.
- Requester must hold `req_valid`, op, mask stable until ack and drop `req_valid` on the edge ending ack; still-high valid after ack is treated as a new request.
- Mask all-zero or op 00: full sequence runs, `q` unchanged, ack issued.
- Reset values: state IDLE, `rr_ptr` 0, `q` 0, `req_ack` 0, `jk_j`/`jk_k` 0, `busy` 0.
- Reset asserted mid-sequence: all state cleared immediately; latched command discarded, no ack.

## Timing
- Edge E1 (valid seen in IDLE): grant latched, state APPLY, `busy`=1, J/K driven during E1→E2.
- Edge E2: `q` updated; state RESP; `req_ack` high E2→E3.
- Edge E3: state IDLE, pointer advanced. Earliest next grant at E4.
- Latency valid→`q` update: 2 edges; valid→ack: ack visible after 2 edges; throughput 1 command / 3 cycles.
- `q`, `req_ack`, `busy` derived from registers only; no combinational path inputs→outputs.
- Simultaneous requests: lowest index at or above `rr_ptr` wins, wrapping past NREQ-1 to 0.

## Configuration
- `JK_BANK_SCHED_FIXED_PRIO_EN` defined: fixed priority, lowest requester index always wins; `rr_ptr` not implemented.
- Undefined (default): round-robin as above.

## Test plan
- Reset: assert `rst_n`=0 mid-APPLY with q=8'hA5 → q=8'h00, ack never pulses, busy=0 immediately.
- Single requester 0, op set, mask 8'h0F from q=0 → q=8'h0F at E2, `req_ack`=4'b0001 for one cycle at E2→E3.
- Toggle requester 2, mask 8'hFF, q=8'h0F → q=8'hF0; second identical toggle → q=8'h0F.
- All four requesters valid continuously (round-robin) → grants in order 0,1,2,3,0; each command 3 cycles apart.
- Same stimulus with `JK_BANK_SCHED_FIXED_PRIO_EN` → requester 0 granted every time while it stays valid.
- Clear with mask 8'h00 on q=8'hFF → q stays 8'hFF, ack still pulses; jk_j=jk_k=0 throughout.
